// File: rtl/buffer_demux_controller.sv
// Read-side link buffer controller: fetches one buffer word at a time and presents it
// to one of four output links, rotating round-robin except while a multi-width chain runs.
module buffer_demux_controller #(
    parameter int DATA_WIDTH = 40,
    parameter int MAX_CHAIN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_multi,
    input  logic [3:0]            link_ready,
    output logic [3:0]            link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    output logic [1:0]            link_num,
    output logic                  out_empty,
    output logic                  chain_err,
    output logic [15:0]           sent_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [3:0] CHAIN_LAST = 4'(MAX_CHAIN - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  multi_q;
    logic [3:0]            chain_cnt;
    logic                  xfer;

    assign xfer      = (state == SEND) && link_ready[link_num];
    // Gated by rst_n so no read strobe escapes while reset is held with data waiting.
    assign rd_en     = rst_n && !in_empty && ((state == IDLE) || xfer);
    assign out_empty = in_empty && (state == IDLE);
    assign link_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            link_num   <= 2'd0;
            link_valid <= 4'b0000;
            data_q     <= '0;
            multi_q    <= 1'b0;
            chain_cnt  <= 4'd0;
            chain_err  <= 1'b0;
            sent_count <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!in_empty) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    data_q     <= rd_data;
                    multi_q    <= rd_multi;
                    link_valid <= 4'b0001 << link_num;
                    state      <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        link_valid <= 4'b0000;
                        sent_count <= sent_count + 16'd1;
                        // A chain at its length limit is cut: move on and flag it.
                        if (multi_q && (chain_cnt < CHAIN_LAST)) begin
                            chain_cnt <= chain_cnt + 4'd1;
                        end else begin
                            link_num  <= link_num + 2'd1;
                            chain_cnt <= 4'd0;
                            if (multi_q) begin
                                chain_err <= 1'b1;
                            end
                        end
                        state <= in_empty ? IDLE : FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_demux_controller.sv
// Bench for buffer_demux_controller: table-driven word sequences, hand-written corner
// sequences and randomized traffic against a word-level reference model.
module tb_buffer_demux_controller;

    localparam int DW   = 40;
    localparam int MAXC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_empty = 1'b1;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          rd_multi = 1'b0;
    logic [3:0]    link_ready = 4'b0000;
    logic [3:0]    link_valid;
    logic [DW-1:0] link_data;
    logic [1:0]    link_num;
    logic          out_empty;
    logic          chain_err;
    logic [15:0]   sent_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rd_en_prev = 1'b0;

    typedef struct {
        logic          multi;
        logic [DW-1:0] data;
    } word_t;

    typedef struct {
        int            link;
        logic [DW-1:0] data;
        int            cyc;
    } obs_t;

    typedef struct {
        string    name;
        int       n;
        logic [7:0] multi;
        int       links[8];
        logic     err;
    } vec_t;

    word_t mem[$];
    obs_t  obs[$];

    buffer_demux_controller #(.DATA_WIDTH(DW), .MAX_CHAIN(MAXC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_empty   (in_empty),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_multi   (rd_multi),
        .link_ready (link_ready),
        .link_valid (link_valid),
        .link_data  (link_data),
        .link_num   (link_num),
        .out_empty  (out_empty),
        .chain_err  (chain_err),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic m, input logic [DW-1:0] d);
        word_t w;
        w.multi = m;
        w.data  = d;
        mem.push_back(w);
        in_empty = 1'b0;
    endtask

    // One clock: observe at the falling edge, then the buffer memory answers a read.
    task automatic tick();
        logic took;
        @(negedge clk);
        took = rd_en;
        if ((link_valid & link_ready) != 4'b0000) begin
            obs_t o;
            o.link = 0;
            for (int i = 0; i < 4; i++) if (link_valid[i]) o.link = i;
            o.data = link_data;
            o.cyc  = cyc;
            obs.push_back(o);
        end
        check("rd_en_back_to_back", 64'(took & rd_en_prev), 64'd0);
        check("link_valid_onehot0", 64'($onehot0(link_valid)), 64'd1);
        if (link_valid != 4'b0000)
            check("link_valid_vs_num", 64'(link_valid), 64'(4'b0001 << link_num));
        rd_en_prev = took;
        @(posedge clk);
        cyc++;
        #2;
        if (took) begin
            if (mem.size() > 0) begin
                word_t w;
                w = mem.pop_front();
                rd_data  = w.data;
                rd_multi = w.multi;
            end else begin
                checks++;
                failures++;
                $display("FAIL rd_en_on_empty actual=1 required=0");
            end
        end
        in_empty = (mem.size() == 0);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        link_ready = 4'b0000;
        mem.delete();
        in_empty   = 1'b1;
        rd_data    = '0;
        rd_multi   = 1'b0;
        rd_en_prev = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 obs.delete();
    endtask

    vec_t  vecs[4];
    word_t src[$];
    int    exp_link[$];
    logic  exp_err;
    int    n, lk, run, pushed;

    initial begin
        vecs[0] = '{name:"rr",    n:5, multi:8'b0000_0000, links:'{0,1,2,3,0,0,0,0}, err:1'b0};
        vecs[1] = '{name:"multi", n:4, multi:8'b0000_0011, links:'{0,0,0,1,0,0,0,0}, err:1'b0};
        vecs[2] = '{name:"chain", n:6, multi:8'b0011_1111, links:'{0,0,0,0,1,1,0,0}, err:1'b1};
        vecs[3] = '{name:"mixed", n:8, multi:8'b1111_0110, links:'{0,1,1,1,2,2,2,2}, err:1'b1};

        // Reset asserted while a chained word is stalled in SEND.
        do_reset();
        check("reset_rd_en", 64'(rd_en), 64'd0);
        check("reset_out_empty", 64'(out_empty), 64'd1);
        for (int i = 0; i < 5; i++) push(1'b1, {8'hC0, 32'(i)});
        link_ready = 4'hF;
        for (int k = 0; k < 40 && obs.size() < 4; k++) tick();
        link_ready = 4'h0;
        tick();
        check("rst_pre_valid", 64'(link_valid), 64'(4'b0010));
        check("rst_pre_err", 64'(chain_err), 64'd1);
        check("rst_pre_count", 64'(sent_count), 64'd4);
        rst_n = 1'b0;
        #1;
        check("rst_link_valid", 64'(link_valid), 64'd0);
        check("rst_link_data", 64'(link_data), 64'd0);
        check("rst_link_num", 64'(link_num), 64'd0);
        check("rst_chain_err", 64'(chain_err), 64'd0);
        check("rst_sent_count", 64'(sent_count), 64'd0);
        check("rst_out_empty", 64'(out_empty), 64'd1);
        in_empty = 1'b0;
        #1;
        check("rst_rd_en_gated", 64'(rd_en), 64'd0);
        in_empty = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("post_rst_rd_en", 64'(rd_en), 64'd0);
            check("post_rst_out_empty", 64'(out_empty), 64'd1);
            tick();
        end

        // Table-driven word sequences with all links ready.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < vecs[r].n; i++) push(vecs[r].multi[i], {8'(r + 1), 24'h0, 8'(i)});
            link_ready = 4'hF;
            #1;
            check({vecs[r].name, "_first_rd_en"}, 64'(rd_en), 64'd1);
            tick();
            check({vecs[r].name, "_fetch_valid"}, 64'(link_valid), 64'd0);
            tick();
            check({vecs[r].name, "_latency_valid"}, 64'(link_valid), 64'(4'b0001));
            for (int k = 0; k < 100 && obs.size() < vecs[r].n; k++) tick();
            check({vecs[r].name, "_words"}, 64'(obs.size()), 64'(vecs[r].n));
            for (int i = 0; i < obs.size() && i < vecs[r].n; i++) begin
                check({vecs[r].name, "_link"}, 64'(obs[i].link), 64'(vecs[r].links[i]));
                check({vecs[r].name, "_data"}, 64'(obs[i].data), 64'({8'(r + 1), 24'h0, 8'(i)}));
                if (i > 0) check({vecs[r].name, "_gap"}, 64'(obs[i].cyc - obs[i-1].cyc), 64'd2);
            end
            tick();
            tick();
            check({vecs[r].name, "_sent_count"}, 64'(sent_count), 64'(vecs[r].n));
            check({vecs[r].name, "_chain_err"}, 64'(chain_err), 64'(vecs[r].err));
            check({vecs[r].name, "_idle_empty"}, 64'(out_empty), 64'd1);
            check({vecs[r].name, "_idle_valid"}, 64'(link_valid), 64'd0);
        end

        // Backpressure on link 0; ready of other links must be ignored.
        do_reset();
        push(1'b0, 40'hA5A5A5A5A5);
        push(1'b0, 40'h0123456789);
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            link_ready = (k >= 3) ? 4'b1110 : 4'b0000;
            #1;
            check("bp_valid", 64'(link_valid), 64'(4'b0001));
            check("bp_data", 64'(link_data), 64'(40'hA5A5A5A5A5));
            check("bp_rd_en", 64'(rd_en), 64'd0);
            tick();
        end
        check("bp_no_xfer", 64'(obs.size()), 64'd0);
        check("bp_count_held", 64'(sent_count), 64'd0);
        link_ready = 4'b0001;
        #1;
        check("bp_release_rd_en", 64'(rd_en), 64'd1);
        tick();
        check("bp_fetch_valid", 64'(link_valid), 64'd0);
        check("bp_fetch_rd_en", 64'(rd_en), 64'd0);
        check("bp_fetch_count", 64'(sent_count), 64'd1);
        check("bp_obs_count", 64'(obs.size()), 64'd1);
        if (obs.size() > 0) check("bp_obs_data", 64'(obs[0].data), 64'(40'hA5A5A5A5A5));
        tick();
        check("bp_next_valid", 64'(link_valid), 64'(4'b0010));
        check("bp_next_data", 64'(link_data), 64'(40'h0123456789));
        link_ready = 4'hF;
        tick();
        check("bp_end_empty", 64'(out_empty), 64'd1);

        // in_empty rises with the last transfer, then falls again in IDLE.
        do_reset();
        push(1'b0, 40'h00000000F1);
        link_ready = 4'hF;
        tick();
        tick();
        check("eb_send_valid", 64'(link_valid), 64'(4'b0001));
        check("eb_send_rd_en", 64'(rd_en), 64'd0);
        tick();
        check("eb_idle_valid", 64'(link_valid), 64'd0);
        check("eb_idle_rd_en", 64'(rd_en), 64'd0);
        check("eb_idle_out_empty", 64'(out_empty), 64'd1);
        tick();
        check("eb_idle2_rd_en", 64'(rd_en), 64'd0);
        push(1'b0, 40'h00000000F2);
        #1;
        check("eb_refill_rd_en", 64'(rd_en), 64'd1);
        check("eb_refill_out_empty", 64'(out_empty), 64'd0);
        tick();
        check("eb_refill_fetch", 64'(link_valid), 64'd0);
        tick();
        check("eb_refill_valid", 64'(link_valid), 64'(4'b0010));
        check("eb_refill_data", 64'(link_data), 64'(40'h00000000F2));
        tick();
        check("eb_end_count", 64'(sent_count), 64'd2);

        // Randomized traffic against a word-level model of link assignment.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            src.delete();
            exp_link.delete();
            n = $urandom_range(10, 40);
            for (int i = 0; i < n; i++) begin
                word_t w;
                w.data  = {8'($urandom), 32'($urandom)};
                w.multi = ($urandom_range(0, 99) < 60);
                src.push_back(w);
            end
            lk = 0;
            run = 0;
            exp_err = 1'b0;
            for (int i = 0; i < n; i++) begin
                exp_link.push_back(lk);
                if (src[i].multi) begin
                    run++;
                    if (run == MAXC) begin
                        lk = (lk + 1) % 4;
                        run = 0;
                        exp_err = 1'b1;
                    end
                end else begin
                    lk = (lk + 1) % 4;
                    run = 0;
                end
            end
            pushed = 0;
            for (int k = 0; k < 4000 && obs.size() < n; k++) begin
                if (pushed < n && $urandom_range(0, 2) == 0) begin
                    push(src[pushed].multi, src[pushed].data);
                    pushed++;
                end
                link_ready = 4'($urandom);
                tick();
            end
            link_ready = 4'hF;
            repeat (3) tick();
            check("rand_words", 64'(obs.size()), 64'(n));
            for (int i = 0; i < obs.size() && i < n; i++) begin
                check("rand_link", 64'(obs[i].link), 64'(exp_link[i]));
                check("rand_data", 64'(obs[i].data), 64'(src[i].data));
            end
            check("rand_sent_count", 64'(sent_count), 64'(16'(n)));
            check("rand_chain_err", 64'(chain_err), 64'(exp_err));
            check("rand_out_empty", 64'(out_empty), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffer_demux_controller.md
# buffer_demux_controller

Read-side controller for the link buffer memory. It drains DATA_WIDTH words from the buffer and presents each word to one of four output links. Link selection rotates round-robin, except that words tagged multi-width stay on the same link. It sits between the buffer memory and the output link mux, and is the counterpart of the write-side controller that merges router link data into the buffer.

## Interface
- DATA_WIDTH, 40, width of one buffer word and of the link data bus
- MAX_CHAIN, 4, maximum number of consecutive words delivered to one link through multi-width chaining (range 1–15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_empty  in  1  buffer memory empty flag
- rd_en  out  1  buffer read strobe; combinational from state, in_empty and link_ready
- rd_data  in  DATA_WIDTH  buffer word, valid the cycle after rd_en
- rd_multi  in  1  multi-width tag stored with the word, valid with rd_data
- link_ready  in  4  per-link ready from the output links
- link_valid  out  4  one-hot valid toward the link mux; 0 when idle
- link_data  out  DATA_WIDTH  registered word presented to the links
- link_num  out  2  link currently selected for the mux
- out_empty  out  1  downstream empty flag = in_empty AND state==IDLE (combinational)
- chain_err  out  1  sticky flag, set when a multi-width chain is forcibly broken
- sent_count  out  16  count of words delivered, wraps

## Operation
- **States:** IDLE, FETCH, SEND.
- **IDLE:** link_valid=0.
  - in_empty=0 → rd_en=1, next state FETCH.
  - Otherwise rd_en=0 and the block stays in IDLE.
- **FETCH:** rd_data and rd_multi are valid this cycle.
  - At the clock edge: data_q←rd_data, multi_q←rd_multi, next state SEND.
  - rd_en=0.
- **SEND:** link_valid = one-hot(link_num); link_data = data_q.
  - A transfer occurs when link_ready[link_num]=1.
  - On transfer, sent_count increments.
  - On transfer, link_num and chain_cnt update:
    - multi_q=0 → link_num←link_num+1 (wrapping 3→0), chain_cnt←0.
    - multi_q=1 and chain_cnt<MAX_CHAIN−1 → link_num is held, chain_cnt increments.
    - multi_q=1 and chain_cnt=MAX_CHAIN−1 → link_num advances, chain_cnt←0, chain_err←1.
  - On transfer with in_empty=0 → rd_en=1 in the same cycle, next state FETCH.
  - On transfer with in_empty=1 → next state IDLE.
  - No transfer → hold everything. rd_en=0, link_data stays stable and link_valid stays asserted.
- Only link_ready[link_num] matters. Ready bits of the other links are ignored.
- in_empty is sampled only in IDLE and on a SEND transfer. A change of in_empty during FETCH has no effect.
- chain_err clears only on reset.

## Timing
- **Reset (asynchronous, immediate):**
  - state=IDLE, link_num=0, link_valid=0, link_data=0, rd_en=0, chain_err=0, sent_count=0, chain_cnt=0, data_q=0, multi_q=0.
  - A word in FETCH or SEND when reset asserts is discarded.
  - There is no partial output after reset.
- **Latency:**
  - in_empty falls during IDLE in cycle N → rd_en=1 in cycle N, FETCH in N+1, link_valid asserted in N+2.
  - Worst case from empty-deassert to link_valid is 2 cycles.
- **Throughput:** one word per 2 cycles while links are ready and the buffer is non-empty (SEND/FETCH alternate).
- **Read strobe:** rd_en is asserted only in IDLE or in a SEND transfer cycle. It is never asserted in two consecutive cycles.
- **Multi-width ordering:** consecutive multi-width words on one link arrive in buffer order, each on a separate SEND cycle.
- **Counter wrap:** sent_count wraps 0xFFFF→0x0000 with no flag.

## Test plan
- **Reset:** hold rst_n=0 mid-SEND with link_ready=0 → all outputs at reset values immediately. After release with in_empty=1 → out_empty=1 and rd_en never asserts.
- **Round-robin:** 5 words, all rd_multi=0, link_ready=4'hF → link_valid sequence 0001, 0010, 0100, 1000, 0001, each 2 cycles apart. sent_count=5. Block returns to IDLE.
- **Backpressure:** word 40'hA5A5A5A5A5 with link_ready[0]=0 for 6 cycles → link_data stable and link_valid=0001 for all 6 cycles, rd_en=0. Raise ready → transfer, then FETCH of the next word.
- **Multi-width:** words tagged multi=1,1,0,0 → first three on link 0, fourth on link 1, chain_err=0.
- **Chain limit (MAX_CHAIN=4):** 6 words all multi=1 → words 1–4 on link 0, words 5–6 on link 1. chain_err=1 after the 4th transfer, and it stays set.
- **Empty boundary:** in_empty rises in the same cycle as a SEND transfer → next state IDLE and rd_en=0. in_empty falls again → rd_en in that cycle and link_valid 2 cycles later.
